// File: rtl/vect_serializer.sv
// Parallel-to-serial transmitter: accepts WIDTH-bit words over valid/ready and emits one bit per clock.
// A one-word hold register keeps consecutive words streaming with no idle cycle between them.
module vect_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic             o_bit,
    output logic             o_bit_valid,
    output logic             o_first,
    output logic             o_last,
    output logic             o_busy
);

    localparam int unsigned CW      = $clog2(WIDTH);
    localparam int unsigned OUT_IDX = LSB_FIRST ? 0 : WIDTH - 1;
    localparam logic [CW-1:0] LAST  = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             accept;

    assign o_ready     = ~i_rst & ~hold_full_q;
    assign accept      = i_valid & o_ready;
    // Shift register is zeroed on return to IDLE, so the output tap is already 0 there.
    assign o_bit       = shreg_q[OUT_IDX];
    assign o_bit_valid = (state_q == SHIFT);
    assign o_first     = first_q;
    assign o_last      = last_q;
    assign o_busy      = busy_q;

    // State and datapath registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            first_q     <= first_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state, load/shift selection and next values of the registered flags
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        first_d     = 1'b0;
        last_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d = i_data;
                    cnt_d   = '0;
                    first_d = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == LAST) begin
                    if (hold_full_q) begin
                        shreg_d     = hold_q;
                        hold_full_d = 1'b0;
                        cnt_d       = '0;
                        first_d     = 1'b1;
                    end else if (accept) begin
                        shreg_d = i_data;
                        cnt_d   = '0;
                        first_d = 1'b1;
                    end else begin
                        shreg_d = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end else begin
                    shreg_d = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
                    cnt_d   = cnt_q + CW'(1);
                    last_d  = (cnt_d == LAST);
                    if (accept) begin
                        hold_d      = i_data;
                        hold_full_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                shreg_d = '0;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d == SHIFT) | hold_full_d;
    end

endmodule
